// File: rtl/exu_muldiv_pkg.sv
// exu_muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - M-extension funct3 codes (INST_MUL .. INST_REMU)
//   - OP-32 major opcode (instructions that set op[3])
//   - FSM state encoding for the wrapper
//   - default datapath width
package exu_muldiv_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [6:0] OPC_OP32 = 7'b0111011;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exu_muldiv_core.sv
// muldiv_core: iterative unsigned datapath, one step per cycle.
//   Multiply: radix-2 shift-add, opa * opb into a 2*XLEN product.
//   Divide:   restoring, opa / opb; opa must arrive left-aligned so its
//             MSB is the first bit consumed within n_iter steps.
// Ports:
//   clk, rst_n, flush   clock, async active-low reset, abort
//   start               load operands and begin (ignored while flush)
//   is_div              1 = divide, 0 = multiply
//   n_iter              number of steps to run
//   opa, opb            magnitudes (multiplicand/multiplier, dividend/divisor)
//   done                one-cycle pulse after the last step
//   prod                multiply result
//   quot, rem           divide results (quotient in the low n_iter bits)
module muldiv_core #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic              is_div,
  input  logic [6:0]        n_iter,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic              done,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);

  logic              busy;
  logic              div_r;
  logic [6:0]        cnt;
  logic [2*XLEN-1:0] acc;
  // multiplicand (shifts left) when multiplying; divisor in the low half when dividing
  logic [2*XLEN-1:0] mcand;
  // multiplier (shifts right) when multiplying; dividend in / quotient out when dividing
  logic [XLEN-1:0]   q_sh;
  logic [XLEN-1:0]   rem_r;

  logic [XLEN:0]     shifted;
  logic              ge;

  assign shifted = {rem_r, q_sh[XLEN-1]};
  assign ge      = shifted >= {1'b0, mcand[XLEN-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      div_r <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      q_sh  <= '0;
      rem_r <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      done  <= 1'b0;
      div_r <= is_div;
      cnt   <= n_iter - 7'd1;
      acc   <= '0;
      rem_r <= '0;
      mcand <= {{XLEN{1'b0}}, is_div ? opb : opa};
      q_sh  <= is_div ? opa : opb;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (div_r) begin
          // when the divisor fits, shifted - divisor is below 2^XLEN
          rem_r <= ge ? (shifted[XLEN-1:0] - mcand[XLEN-1:0]) : shifted[XLEN-1:0];
          q_sh  <= {q_sh[XLEN-2:0], ge};
        end else begin
          if (q_sh[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          q_sh  <= q_sh >> 1;
        end
        if (cnt == 7'd0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 7'd1;
        end
      end
    end
  end

  assign prod = acc;
  assign quot = q_sh;
  assign rem  = rem_r;

endmodule

// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV64IM multiply/divide unit with valid/ready on both
// sides. Signed operands are reduced to magnitudes at accept, the core
// iterates on unsigned values, and the sign is reapplied when the result is
// registered on entry to DONE.
// Ports:
//   clk, rst_n, flush            clock, async active-low reset, pipeline flush
//   in_valid/in_ready            request handshake (ready only in IDLE)
//   op                           {word, funct3}
//   src1, src2                   operands, sampled only at accept
//   waddr_i                      destination register, echoed on wd_o
//   out_valid/out_ready          result handshake
//   wdata_o, wd_o, wreg_o        result, destination, write enable
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      waddr_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o
);

  localparam logic [6:0] N_FULL = 7'(XLEN);

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    if (sgn) ext32 = XLEN'($signed(v));
    else     ext32 = XLEN'(v);
  endfunction

  state_e state, state_nx;

  // ---- request decode ----
  logic [2:0]      f3;
  logic            word, is_div_in, illegal_in, s1_in, s2_in, neg1_in, neg2_in;
  logic            div_zero_in, ovf_in, special_in, early_in, accept;
  logic [XLEN-1:0] ext1, ext2, abs1, abs2, dividend_sx, core_a, spec_val_in;
  logic [6:0]      n_in;

  assign f3         = op[2:0];
  assign word       = op[3];
  assign is_div_in  = f3[2];
  assign illegal_in = word && ((XLEN != 64) || (!f3[2] && (f3 != INST_MUL)));
  assign s1_in      = (f3 == INST_MULH) || (f3 == INST_MULHSU) || (f3 == INST_DIV) || (f3 == INST_REM);
  assign s2_in      = (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);

  assign ext1    = word ? ext32(src1[31:0], s1_in) : src1;
  assign ext2    = word ? ext32(src2[31:0], s2_in) : src2;
  assign neg1_in = s1_in && ext1[XLEN-1];
  assign neg2_in = s2_in && ext2[XLEN-1];
  assign abs1    = neg1_in ? -ext1 : ext1;
  assign abs2    = neg2_in ? -ext2 : ext2;
  assign n_in    = word ? 7'd32 : N_FULL;
  // restoring division consumes dividend bits from the MSB of the register
  assign core_a  = is_div_in ? (abs1 << (N_FULL - n_in)) : abs1;

  assign dividend_sx = word ? ext32(src1[31:0], 1'b1) : src1;
  assign div_zero_in = is_div_in && (word ? (src2[31:0] == 32'd0) : (src2 == '0));
  assign ovf_in      = is_div_in && !f3[0] &&
                       (word ? ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF))
                             : ((src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1)));
  assign special_in  = illegal_in || div_zero_in || ovf_in;
  assign early_in    = illegal_in || (EARLY_OUT && (div_zero_in || ovf_in));

  always_comb begin
    spec_val_in = '0;
    if (!illegal_in) begin
      if (div_zero_in)  spec_val_in = f3[1] ? dividend_sx : '1;
      else if (ovf_in)  spec_val_in = f3[1] ? '0 : dividend_sx;
    end
  end

  assign accept = in_valid && (state == ST_IDLE) && !flush;

  // ---- latched request ----
  logic [2:0]      f3_r;
  logic            word_r, neg1_r, neg2_r, special_r, early_r;
  logic [XLEN-1:0] spec_val_r;

  logic              core_done;
  logic [2*XLEN-1:0] core_prod;
  logic [XLEN-1:0]   core_quot, core_rem;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (accept && !early_in),
    .is_div (is_div_in),
    .n_iter (n_in),
    .opa    (core_a),
    .opb    (abs2),
    .done   (core_done),
    .prod   (core_prod),
    .quot   (core_quot),
    .rem    (core_rem)
  );

  // ---- result selection ----
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, res, res_fin;
  logic              load_res;

  assign prod_s = (neg1_r ^ neg2_r) ? -core_prod : core_prod;
  assign quot_s = (neg1_r ^ neg2_r) ? -core_quot : core_quot;
  assign rem_s  = neg1_r ? -core_rem : core_rem;

  always_comb begin
    res = '0;
    case (f3_r)
      INST_MUL:                          res = prod_s[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: res = prod_s[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:               res = quot_s;
      default:                           res = rem_s;
    endcase
  end

  assign res_fin  = special_r ? spec_val_r : (word_r ? ext32(res[31:0], 1'b1) : res);
  assign load_res = (state == ST_CALC) && (early_r || core_done) && !flush;

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_CALC;
      // early-out requests spend one cycle here with the core left idle
      ST_CALC: if (early_r || core_done) state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_r       <= '0;
      word_r     <= 1'b0;
      neg1_r     <= 1'b0;
      neg2_r     <= 1'b0;
      special_r  <= 1'b0;
      early_r    <= 1'b0;
      spec_val_r <= '0;
      wd_o       <= '0;
      wdata_o    <= '0;
    end else begin
      if (accept) begin
        f3_r       <= f3;
        word_r     <= word;
        neg1_r     <= neg1_in;
        neg2_r     <= neg2_in;
        special_r  <= special_in;
        early_r    <= early_in;
        spec_val_r <= spec_val_in;
        wd_o       <= waddr_i;
      end
      if (load_res) wdata_o <= res_fin;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign wreg_o    = out_valid && (wd_o != 5'd0);

endmodule
